// File: rtl/iob_pcie_chnl_tx_pkg.sv
// Shared definitions for the PCIe channel RX-side transmitter: FSM state encoding and channel width.
package iob_pcie_chnl_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int CHNL_DATA_W = 64;

endpackage

// File: rtl/iob_pcie_chnl_tx_if.sv
// Channel RX port bundle: the transmitter drives request/length/offset/last/data, the channel returns ack/ren.
// Handshake: a beat transfers on every clock edge where rx_data_valid and rx_data_ren are both 1;
// the request is accepted on the edge where rx and rx_ack are both 1.
interface iob_pcie_chnl_tx_if #(
    parameter int DATA_W = 32,
    parameter int CHNL_W = 64
);
    logic              rx;
    logic              rx_last;
    logic [DATA_W-1:0] rx_len;
    logic [DATA_W-2:0] rx_off;
    logic [CHNL_W-1:0] rx_data;
    logic              rx_data_valid;
    logic              rx_data_ren;
    logic              rx_ack;

    modport master (
        output rx, rx_last, rx_len, rx_off, rx_data, rx_data_valid,
        input  rx_data_ren, rx_ack
    );

    modport slave (
        input  rx, rx_last, rx_len, rx_off, rx_data, rx_data_valid,
        output rx_data_ren, rx_ack
    );
endinterface

// File: rtl/iob_pcie_chnl_tx_cnt.sv
// Loadable down-counter with zero flag; used for beats still to load and beats still to consume.
module iob_pcie_chnl_tx_cnt #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/iob_pcie_chnl_tx.sv
// Host-side transmitter into a PCIe user channel RX port: request, wait for ack, stream 64-bit beats.
// Optional ack timeout with sticky err_o is built when IOB_PCIE_CHNL_TX_TIMEOUT_EN is defined.
module iob_pcie_chnl_tx
    import iob_pcie_chnl_tx_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int ACK_TIMEOUT      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [DATA_W-1:0]           len_i,
    input  logic [DATA_W-2:0]           off_i,
    input  logic                        last_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] src_data_i,
    input  logic                        src_valid_i,
    output logic                        src_ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    iob_pcie_chnl_tx_if.master          chnl,
    output state_t                      dbg_state,
    output logic [DATA_W:0]             dbg_load_left,
    output logic [DATA_W:0]             dbg_cons_left
);

    if (C_PCI_DATA_WIDTH != CHNL_DATA_W) begin : g_bad_width
        $error("iob_pcie_chnl_tx: C_PCI_DATA_WIDTH must be 64");
    end
    if (ACK_TIMEOUT < 2) begin : g_bad_timeout
        $error("iob_pcie_chnl_tx: ACK_TIMEOUT must be at least 2");
    end

    state_t                      state, state_nxt;
    logic                        accept, load, consume, final_beat, timeout, empty_ack;
    logic [C_PCI_DATA_WIDTH-1:0] data_q;
    logic                        valid_q, done_q, last_q;
    logic [DATA_W-1:0]           len_q;
    logic [DATA_W-2:0]           off_q;
    logic [DATA_W:0]             beats_calc, load_left, cons_left;
    logic                        load_zero, cons_zero;

    // One extra bit keeps len = all-ones from wrapping to zero beats.
    assign beats_calc = ({1'b0, len_i} + {{DATA_W{1'b0}}, 1'b1}) >> 1;

    // A start coinciding with the done pulse is dropped so back-to-back requests are explicit.
    assign accept      = (state == ST_IDLE) && start_i && !done_q;
    assign consume     = valid_q && chnl.rx_data_ren;
    assign src_ready_o = (state == ST_DATA) && (!valid_q || chnl.rx_data_ren) && !load_zero;
    assign load        = src_ready_o && src_valid_i;
    assign final_beat  = (state == ST_DATA) && consume && (cons_left == {{DATA_W{1'b0}}, 1'b1});
    assign empty_ack   = (state == ST_REQ) && chnl.rx_ack && cons_zero;

    iob_pcie_chnl_tx_cnt #(.W(DATA_W + 1)) u_load_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (beats_calc),
        .dec      (load),
        .cnt      (load_left),
        .zero     (load_zero)
    );

    iob_pcie_chnl_tx_cnt #(.W(DATA_W + 1)) u_cons_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (beats_calc),
        .dec      (consume),
        .cnt      (cons_left),
        .zero     (cons_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_REQ;
            ST_REQ: begin
                if (chnl.rx_ack) begin
                    state_nxt = cons_zero ? ST_IDLE : ST_DATA;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: if (final_beat) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            off_q  <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            len_q  <= len_i;
            off_q  <= off_i;
            last_q <= last_i;
        end
    end

    // Single output stage: holds the beat until the channel takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) data_q <= src_data_i;
            if (load) begin
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= empty_ack || final_beat;
        end
    end

`ifdef IOB_PCIE_CHNL_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign timeout = (state == ST_REQ) && !chnl.rx_ack && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ST_REQ) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign busy_o             = (state != ST_IDLE);
    assign done_o             = done_q;
    assign chnl.rx            = (state != ST_IDLE);
    assign chnl.rx_last       = last_q;
    assign chnl.rx_len        = len_q;
    assign chnl.rx_off        = off_q;
    assign chnl.rx_data       = data_q;
    assign chnl.rx_data_valid = valid_q;

    assign dbg_state     = state;
    assign dbg_load_left = load_left;
    assign dbg_cons_left = cons_left;

endmodule

// File: tb/tb_iob_pcie_chnl_tx.sv
// Randomized bench for iob_pcie_chnl_tx with a transaction-level reference model and beat scoreboard.
module tb_iob_pcie_chnl_tx;
    import iob_pcie_chnl_tx_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ACK_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [DATA_W-1:0] len_i;
    logic [DATA_W-2:0] off_i;
    logic              last_i;
    logic [63:0]       src_data_i;
    logic              src_valid_i;
    logic              src_ready_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    state_t            dbg_state;
    logic [DATA_W:0]   dbg_load_left;
    logic [DATA_W:0]   dbg_cons_left;

    iob_pcie_chnl_tx_if #(.DATA_W(DATA_W), .CHNL_W(64)) chnl ();

    iob_pcie_chnl_tx #(
        .DATA_W           (DATA_W),
        .C_PCI_DATA_WIDTH (64),
        .ACK_TIMEOUT      (ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .len_i         (len_i),
        .off_i         (off_i),
        .last_i        (last_i),
        .src_data_i    (src_data_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .chnl          (chnl),
        .dbg_state     (dbg_state),
        .dbg_load_left (dbg_load_left),
        .dbg_cons_left (dbg_cons_left)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        start_i          = 1'b0;
        len_i            = '0;
        off_i            = '0;
        last_i           = 1'b0;
        src_data_i       = '0;
        src_valid_i      = 1'b0;
        chnl.rx_data_ren = 1'b0;
        chnl.rx_ack      = 1'b0;
    endtask

    task automatic check_idle_zero(input string pfx);
        check({pfx, "_rx"}, chnl.rx, 0);
        check({pfx, "_last"}, chnl.rx_last, 0);
        check({pfx, "_len"}, chnl.rx_len, 0);
        check({pfx, "_off"}, chnl.rx_off, 0);
        check({pfx, "_data"}, chnl.rx_data, 0);
        check({pfx, "_dv"}, chnl.rx_data_valid, 0);
        check({pfx, "_src_ready"}, src_ready_o, 0);
        check({pfx, "_busy"}, busy_o, 0);
        check({pfx, "_done"}, done_o, 0);
        check({pfx, "_err"}, err_o, 0);
    endtask

    // One full transaction; the channel acks in REQ cycle ack_dly (0 = first REQ cycle).
    task automatic run_txn(input logic [DATA_W-1:0] len, input logic [DATA_W-2:0] off, input logic last,
                           input int ack_dly, input int src_pct, input int ren_pct);
        logic [63:0] beats;
        logic [63:0] src_beats[$];
        logic [63:0] d;
        int          src_idx, req_cyc, rx_cyc, cyc;
        bit          in_data, first_data, want_done, fin;

        beats = (64'(len) + 64'd1) >> 1;
        exp_q.delete();
        for (int i = 0; i < int'(beats); i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back(d);
            src_beats.push_back(d);
        end

        @(negedge clk);
        start_i = 1'b1;
        len_i   = len;
        off_i   = off;
        last_i  = last;
        @(negedge clk);
        start_i = 1'b0;
        len_i   = DATA_W'($urandom);
        off_i   = (DATA_W-1)'($urandom);
        last_i  = ~last;
        check("req_rx", chnl.rx, 1);
        check("req_busy", busy_o, 1);
        check("req_len", chnl.rx_len, len);
        check("req_off", chnl.rx_off, off);
        check("req_last", chnl.rx_last, last);

        src_idx = 0; req_cyc = 0; rx_cyc = 0; cyc = 0;
        in_data = 0; first_data = 0; want_done = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            if (want_done) begin
                check("done_pulse", done_o, 1);
                check("done_rx", chnl.rx, 0);
                check("done_dv", chnl.rx_data_valid, 0);
                check("done_busy", busy_o, 0);
                fin = 1;
            end else begin
                if (chnl.rx) rx_cyc++;
                check("early_done", done_o, 0);
                if (!in_data) begin
                    check("req_dv", chnl.rx_data_valid, 0);
                    check("req_hold", chnl.rx, 1);
                    chnl.rx_ack      = (req_cyc == ack_dly);
                    src_valid_i      = 1'b0;
                    chnl.rx_data_ren = 1'($urandom_range(0, 1));
                    req_cyc++;
                    if (chnl.rx_ack) begin
                        if (beats == 0) begin
                            want_done = 1;
                        end else begin
                            in_data    = 1;
                            first_data = 1;
                        end
                    end
                end else begin
                    chnl.rx_ack = 1'($urandom_range(0, 1));
                    if (first_data) check("ack_to_dv", chnl.rx_data_valid, 0);
                    first_data = 0;
                    if (chnl.rx_data_valid) begin
                        if (exp_q.size() == 0) check("extra_beat", chnl.rx_data_valid, 0);
                        else check("beat_data", chnl.rx_data, exp_q[0]);
                    end
                    if (src_idx < int'(beats)) begin
                        src_valid_i = ($urandom_range(1, 100) <= src_pct);
                        src_data_i  = src_beats[src_idx];
                    end else begin
                        src_valid_i = 1'($urandom_range(0, 1));
                        src_data_i  = {$urandom, $urandom};
                    end
                    chnl.rx_data_ren = ($urandom_range(1, 100) <= ren_pct);
                    #1;
                    if (src_valid_i && src_ready_o) begin
                        check("no_overfetch", 64'(src_idx < int'(beats)), 1);
                        src_idx++;
                    end
                    if (chnl.rx_data_valid && chnl.rx_data_ren && exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) want_done = 1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("txn_complete", 64'(fin), 1);

        // A start in the done cycle must not open a new transaction.
        chnl.rx_ack      = 1'b0;
        src_valid_i      = 1'b0;
        chnl.rx_data_ren = 1'b0;
        start_i          = 1'b1;
        len_i            = 4;
        @(negedge clk);
        start_i = 1'b0;
        check("start_in_done", chnl.rx, 0);
        check("done_once", done_o, 0);
        if (beats == 0) check("rx_cycles_empty", 64'(rx_cyc), 64'(ack_dly + 1));
        else if (src_pct == 100 && ren_pct == 100)
            check("rx_cycles", 64'(rx_cyc), 64'(ack_dly + 1) + beats + 1);
`ifndef IOB_PCIE_CHNL_TX_TIMEOUT_EN
        check("err_tied", err_o, 0);
`endif
    endtask

    // Reset while the second of four beats is waiting in the output stage.
    task automatic reset_mid();
        @(negedge clk);
        start_i = 1'b1; len_i = 8; off_i = 5; last_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; chnl.rx_ack = 1'b1; src_valid_i = 1'b1;
        src_data_i = {$urandom, $urandom}; chnl.rx_data_ren = 1'b1;
        @(negedge clk);
        chnl.rx_ack = 1'b0; src_data_i = {$urandom, $urandom};
        @(negedge clk);
        check("rm_first_dv", chnl.rx_data_valid, 1);
        src_data_i = {$urandom, $urandom};
        @(negedge clk);
        check("rm_busy", busy_o, 1);
        rst = 1'b1; src_valid_i = 1'b0; chnl.rx_data_ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("rm");
    endtask

    // len = all-ones must yield a huge beat count, not zero.
    task automatic len_max();
        @(negedge clk);
        start_i = 1'b1; len_i = '1; off_i = '0; last_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; chnl.rx_ack = 1'b1;
        @(negedge clk);
        chnl.rx_ack = 1'b0; src_valid_i = 1'b1; src_data_i = 64'h0123_4567_89ab_cdef; chnl.rx_data_ren = 1'b1;
        #1;
        check("max_src_ready", src_ready_o, 1);
        check("max_busy", busy_o, 1);
        check("max_no_done", done_o, 0);
        @(negedge clk);
        check("max_dv", chnl.rx_data_valid, 1);
        check("max_data", chnl.rx_data, 64'h0123_4567_89ab_cdef);
        rst = 1'b1; src_valid_i = 1'b0; chnl.rx_data_ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("max_rst");
    endtask

`ifdef IOB_PCIE_CHNL_TX_TIMEOUT_EN
    task automatic ack_timeout();
        int n;
        @(negedge clk);
        start_i = 1'b1; len_i = 4; off_i = 0; last_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (chnl.rx && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 64'(n), ACK_TIMEOUT);
        check("tmo_err", err_o, 1);
        check("tmo_no_done", done_o, 0);
        check("tmo_busy", busy_o, 0);
        start_i = 1'b1; len_i = 0;
        @(negedge clk);
        start_i = 1'b0; chnl.rx_ack = 1'b1;
        check("tmo_err_clear", err_o, 0);
        @(negedge clk);
        chnl.rx_ack = 1'b0;
        check("tmo_recover_done", done_o, 1);
        @(negedge clk);
    endtask
`endif

    initial begin
        int src_pcts[3];
        src_pcts[0] = 100; src_pcts[1] = 70; src_pcts[2] = 40;
        rst = 1'b1;
        drive_quiet();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        run_txn(4, 0, 1'b1, 3, 100, 100);
        run_txn(5, 31'h7, 1'b0, 0, 100, 100);
        run_txn(2, 31'h1, 1'b1, 1, 50, 50);
        run_txn(0, 31'h3, 1'b1, 2, 100, 100);
`ifndef IOB_PCIE_CHNL_TX_TIMEOUT_EN
        run_txn(3, 31'h2, 1'b0, 40, 100, 100);
`endif
        reset_mid();
        run_txn(2, 31'h9, 1'b0, 0, 100, 100);
        len_max();
`ifdef IOB_PCIE_CHNL_TX_TIMEOUT_EN
        ack_timeout();
`endif
        for (int t = 0; t < 25; t++) begin
            run_txn(DATA_W'($urandom_range(0, 11)), (DATA_W-1)'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 12), src_pcts[$urandom_range(0, 2)], src_pcts[$urandom_range(0, 2)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
